// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter (LSB first, idle high) fed by a small byte FIFO.
// A queued byte is framed as start bit, eight data bits, stop bit; frames run back to back.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] LAST_TICK  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_fifo: CLK_FREQ / BAUD must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   baud_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [7:0]         head;

  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               bit_done;

  assign fifo_empty = (fifo_count == '0);
  assign tx_ready   = (fifo_count != FULL_COUNT);
  assign busy       = (state != IDLE) || !fifo_empty;
  assign bit_done   = (baud_cnt == LAST_TICK);
  assign head       = mem[rd_ptr];
  assign push       = tx_valid && tx_ready;

  // The FSM takes the head byte either from idle or at the very end of a stop bit,
  // which is what makes consecutive frames contiguous.
  assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          tx       <= 1'b1;
          if (pop) begin
            shift <= head;
            state <= START;
            tx    <= 1'b0;
          end
        end

        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // The shift register moves right so the next bit is always at shift[1].
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= head;
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: directed scenarios plus random traffic, checked against
// a frame-timeline model (queue of bytes plus position within the current 10-bit frame).
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 250;
  localparam int DEPTH    = 4;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * CPB;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic [7:0]               tx_data = 8'h00;
  logic                     tx_valid = 1'b0;
  logic                     tx_ready;
  logic                     tx;
  logic                     busy;
  logic [$clog2(DEPTH):0]   fifo_count;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  int         fc = -1;
  logic [7:0] cur = 8'h00;

  uart_tx_fifo #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Model: fc is the cycle offset inside the current frame, -1 when the line is idle.
  function automatic logic exp_tx();
    int b;
    if (fc < 0) return 1'b1;
    b = fc / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  function automatic logic exp_busy();
    return (fc >= 0) || (q.size() != 0);
  endfunction

  function automatic logic exp_ready();
    return q.size() != DEPTH;
  endfunction

  function automatic logic [$clog2(DEPTH):0] exp_count();
    return ($clog2(DEPTH)+1)'(q.size());
  endfunction

  task automatic tick(input logic v, input logic [7:0] d, input logic rn);
    bit do_pop;
    bit do_push;
    tx_valid = v;
    tx_data  = d;
    rst_n    = rn;
    @(posedge clk);
    if (!rn) begin
      q.delete();
      fc = -1;
    end else begin
      do_push = v && (q.size() != DEPTH);
      do_pop  = (q.size() != 0) && ((fc < 0) || (fc == FRAME - 1));
      if (do_pop) begin
        cur = q.pop_front();
        fc  = 0;
      end else if (fc == FRAME - 1) begin
        fc = -1;
      end else if (fc >= 0) begin
        fc++;
      end
      if (do_push) q.push_back(d);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_reset();
    tick(1'b1, 8'hAA, 1'b0);
    checks++; if (tx !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fifo_count !== 0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", tx_ready); end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL idle_line cycle=%0d got tx=%b busy=%b ready=%b exp 1/0/1", i, tx, busy, tx_ready);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [9:0] frame;
    frame = {1'b1, 8'h52, 1'b0};
    tick(1'b1, 8'h52, 1'b1);
    checks++; if (fifo_count !== 1 || tx !== 1'b1) begin failures++; $display("[TB] FAIL single_accept got count=%0d tx=%b exp 1/1", fifo_count, tx); end
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      checks++;
      if (tx !== frame[i / CPB] || tx !== exp_tx()) begin
        failures++;
        $display("[TB] FAIL single_tx cycle=%0d got=%b exp=%b", i, tx, frame[i / CPB]);
      end
    end
    tick(1'b0, 8'h00, 1'b1);
    checks++; if (busy !== 1'b0 || tx !== 1'b1) begin failures++; $display("[TB] FAIL single_end got busy=%b tx=%b exp 0/1", busy, tx); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    int max_count;
    int busy_run;
    bytes = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    max_count = 0;
    busy_run  = 0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready byte=%0d got=%b exp=1", k, tx_ready); end
      tick(1'b1, bytes[k], 1'b1);
      if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
      if (busy === 1'b1) busy_run++;
    end
    checks++; if (max_count != 3) begin failures++; $display("[TB] FAIL b2b_peak got=%0d exp=3", max_count); end
    for (int i = 0; i < 5 * FRAME; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      if (busy === 1'b1) busy_run++;
      checks++;
      if (tx !== exp_tx()) begin
        failures++;
        $display("[TB] FAIL b2b_tx cycle=%0d got=%b exp=%b", i, tx, exp_tx());
      end
    end
    checks++; if (busy_run != 4 * FRAME + 1) begin failures++; $display("[TB] FAIL b2b_busy_span got=%0d exp=%0d", busy_run, 4 * FRAME + 1); end
  endtask

  task automatic test_fill_full();
    tick(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_ready_pre byte=%0d got=%b exp=1", k, tx_ready); end
      tick(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    end
    checks++; if (fifo_count !== 4 || tx_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_state got count=%0d ready=%b exp 4/0", fifo_count, tx_ready); end
    tick(1'b1, 8'hEE, 1'b1);
    checks++; if (fifo_count !== 4) begin failures++; $display("[TB] FAIL full_drop got count=%0d exp=4", fifo_count); end
    for (int i = 0; i < 7 * FRAME; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      checks++;
      if (tx !== exp_tx() || tx_ready !== exp_ready() || fifo_count !== exp_count()) begin
        failures++;
        $display("[TB] FAIL full_drain cycle=%0d got tx=%b ready=%b count=%0d exp %b/%b/%0d",
                 i, tx, tx_ready, fifo_count, exp_tx(), exp_ready(), exp_count());
      end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL full_end_busy got=%b exp=0", busy); end
  endtask

  task automatic test_push_pop_same_edge();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 3; k++) tick(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (fc == FRAME - 1) found = 1'b1;
      else tick(1'b0, 8'h00, 1'b1);
    end
    checks++; if (!found) begin failures++; $display("[TB] FAIL pushpop_reach got=timeout exp=stop_end"); end
    checks++; if (fifo_count !== 2) begin failures++; $display("[TB] FAIL pushpop_pre got count=%0d exp=2", fifo_count); end
    tick(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    checks++; if (fifo_count !== 2) begin failures++; $display("[TB] FAIL pushpop_count got=%0d exp=2", fifo_count); end
    for (int i = 0; i < 4 * FRAME; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      checks++;
      if (tx !== exp_tx() || fifo_count !== exp_count()) begin
        failures++;
        $display("[TB] FAIL pushpop_tx cycle=%0d got tx=%b count=%0d exp %b/%0d", i, tx, fifo_count, exp_tx(), exp_count());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      tick(($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)), 1'b1);
      checks++;
      if (tx !== exp_tx() || busy !== exp_busy() || tx_ready !== exp_ready() || fifo_count !== exp_count()) begin
        failures++;
        $display("[TB] FAIL random cycle=%0d got tx=%b busy=%b ready=%b count=%0d exp %b/%b/%b/%0d",
                 i, tx, busy, tx_ready, fifo_count, exp_tx(), exp_busy(), exp_ready(), exp_count());
      end
    end
    for (int i = 0; i < (DEPTH + 2) * FRAME; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      checks++;
      if (tx !== exp_tx() || busy !== exp_busy()) begin
        failures++;
        $display("[TB] FAIL random_drain cycle=%0d got tx=%b busy=%b exp %b/%b", i, tx, busy, exp_tx(), exp_busy());
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 3; k++) tick(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (fc == 4 * CPB + 1) found = 1'b1;
      else tick(1'b0, 8'h00, 1'b1);
    end
    checks++; if (!found) begin failures++; $display("[TB] FAIL midreset_reach got=timeout exp=data_bit3"); end
    checks++; if (fifo_count !== 2 || busy !== 1'b1) begin failures++; $display("[TB] FAIL midreset_pre got count=%0d busy=%b exp 2/1", fifo_count, busy); end
    tick(1'b0, 8'h00, 1'b0);
    checks++; if (tx !== 1'b1) begin failures++; $display("[TB] FAIL midreset_tx got=%b exp=1", tx); end
    checks++; if (fifo_count !== 0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_state got count=%0d busy=%b exp 0/0", fifo_count, busy); end
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midreset_quiet cycle=%0d got tx=%b busy=%b exp 1/0", i, tx, busy);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle();
    test_single_frame();
    test_back_to_back();
    test_fill_full();
    test_push_pop_same_edge();
    test_random();
    test_reset_mid_frame();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- 8N1 UART transmitter: serialises bytes to the host over the same serial link the RGB command receiver listens on.
- Fronted by a small byte FIFO, so the control logic can queue short replies (for example an ack byte after an 'R' reset command) without stalling.
- Single clock domain, driven directly by the board clock.
- No parity, one stop bit, LSB first, line idles high.

Parameters:
- CLK_FREQ, 12000000: input clock frequency in Hz.
- BAUD, 115200: serial bit rate.
- FIFO_DEPTH, 4: byte FIFO depth. Must be a power of 2, at least 2.
- Derived constant CLKS_PER_BIT = CLK_FREQ / BAUD, using truncating integer division. Elaboration must fail if CLKS_PER_BIT < 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- tx_data  input  8  byte to queue.
- tx_valid  input  1  tx_data is valid this cycle.
- tx_ready  output  1  FIFO can accept a byte this cycle.
- tx  output  1  serial line, registered output.
- busy  output  1  high while a frame is in flight or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes currently queued.

Behaviour:
- Reset:
  - Reset is one clock, synchronous, active-low. While rst_n=0 on a rising edge: state=IDLE, FIFO flushed (fifo_count=0), tx=1, busy=0, baud and bit counters cleared.
  - tx_ready = (fifo_count != FIFO_DEPTH). It reads 1 on the first cycle after reset.
  - tx_valid is ignored on any edge where rst_n=0.
  - Reset mid-frame abandons the frame: tx is 1 after that edge and the queued bytes are lost.
- Push:
  - A byte is accepted on an edge where tx_valid && tx_ready. tx_ready depends only on registered state; there is no combinational path from tx_valid.
  - tx_valid while full: no write, no error, data dropped by caller's choice.
  - Simultaneous push and pop on the same edge leaves fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty on an edge: pop head into the shift register and go to START. tx=0 from that edge.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0. tx = shift[0].
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7 completes, go to STOP with tx=1.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. At the end: if the FIFO is non-empty, pop and go straight to START (no extra idle cycle); else go to IDLE.
- Timing:
  - Latency: a byte accepted at edge E into an empty FIFO with the FSM in IDLE drives tx=0 after edge E+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames have no gap between stop and the next start.
  - The baud counter counts 0..CLKS_PER_BIT-1. It reloads at every state or bit transition and is not free-running.
- busy = (state != IDLE) || (fifo_count != 0). Registered-state derived.
- A push into an empty FIFO on the same edge the FSM is in IDLE is seen as non-empty on the next edge; there is no same-cycle bypass.

Test Plan:
- CLK_FREQ=1000, BAUD=250 (4 clk/bit), reset then push 8'h52 -> tx=0 one edge after acceptance. Sequence 0 | 0,1,0,0,1,0,1,0 | 1, each value held exactly 4 cycles. Total 40 cycles, then busy=0.
- Push 4 bytes 8'h00, 8'hFF, 8'hA5, 8'h3C on consecutive cycles -> tx_ready=1 throughout. fifo_count peaks at 3, because the first byte is popped. Four contiguous frames with no idle gap, 160 cycles total.
- Fill FIFO while a frame is active -> fifo_count=4, tx_ready=0. A 5th tx_valid byte is dropped. tx_ready returns to 1 on the edge after the next pop.
- Push and pop on the same edge (count=2, STOP ending, tx_valid=1) -> fifo_count stays 2. Byte order is preserved across pointer wrap.
- Assert rst_n=0 for one edge during DATA bit 3 with 2 bytes queued -> tx=1 after that edge, fifo_count=0, busy=0. No further frame is emitted.
- Idle line check: no pushes for 100 cycles after reset -> tx=1, busy=0, tx_ready=1 constant.
